// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the conv-encoder -> channel -> Viterbi link: enc_en/enc_din 1 cycle after the source handshake, dec_en/err_mask 1 cycle later.
// Source backpressure via src_ready (high only in SEND); optional BER counters under `VITERBI_CTRL_BER_COUNT_EN.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN       = 256,
  parameter int TAIL_LEN        = 2,
  parameter int DEC_LAT         = 16,
  parameter int ERR_PERIOD_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       err_en,
  input  logic [1:0] err_pattern,
  input  logic       src_valid,
  input  logic       src_bit,
  output logic       src_ready,
  output logic       enc_en,
  output logic       enc_din,
  output logic       dec_en,
  output logic [1:0] err_mask,
  output logic       busy,
  output logic       frame_done
`ifdef VITERBI_CTRL_BER_COUNT_EN
  ,
  input  logic        dec_bit,
  output logic [15:0] inj_bit_cnt,
  output logic [15:0] dec_err_cnt
`endif
);

  typedef enum logic [2:0] {ST_IDLE, ST_SEND, ST_TAIL, ST_DRAIN, ST_DONE} state_t;

  localparam int SYM_W   = $clog2(FRAME_LEN + TAIL_LEN + DEC_LAT + 1);
  localparam int CNT_A   = (FRAME_LEN > TAIL_LEN) ? FRAME_LEN : TAIL_LEN;
  localparam int CNT_MAX = (CNT_A > DEC_LAT + 2) ? CNT_A : DEC_LAT + 2;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_SEND_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] C_TAIL_LAST  = CNT_W'(TAIL_LEN - 1);
  localparam logic [CNT_W-1:0] C_DRAIN_REQ  = CNT_W'(DEC_LAT);
  localparam logic [CNT_W-1:0] C_DRAIN_LAST = CNT_W'(DEC_LAT + 1);
  localparam logic [SYM_W-1:0] C_ERR_LIMIT  = SYM_W'(FRAME_LEN + TAIL_LEN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [SYM_W-1:0] r_sym_idx;
  logic             r_enc_en;
  logic             r_enc_din;
  logic             r_dec_en;
  logic [1:0]       r_err_mask;
  logic             r_err_en;
  logic [1:0]       r_err_pat;
  logic             w_hs;
  logic             w_abort;
  logic             w_start_frame;
  logic             w_enc_req;
  logic             w_enc_bit;
  logic             w_err_hit;

  assign src_ready  = (r_state == ST_SEND);
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);
  assign enc_en     = r_enc_en;
  assign enc_din    = r_enc_din;
  assign dec_en     = r_dec_en;
  assign err_mask   = r_err_mask;

  assign w_hs          = src_valid & src_ready;
  assign w_abort       = abort & busy;
  assign w_start_frame = start & (r_state == ST_IDLE);
  // r_sym_idx is the index of the symbol that r_enc_en turns into dec_en next cycle
  assign w_err_hit = r_enc_en & r_err_en & (r_sym_idx < C_ERR_LIMIT)
                   & (&r_sym_idx[ERR_PERIOD_LOG2-1:1]);

  always_comb begin
    w_state_nxt = r_state;
    w_enc_req   = 1'b0;
    w_enc_bit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_hs) begin
          w_enc_req = 1'b1;
          w_enc_bit = src_bit;
          if (r_cnt == C_SEND_LAST) w_state_nxt = ST_TAIL;
        end
      end
      ST_TAIL: begin
        w_enc_req = 1'b1;
        if (r_cnt == C_TAIL_LAST) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // two extra idle cycles let the last request reach dec_en before DONE
        w_enc_req = (r_cnt < C_DRAIN_REQ);
        if (r_cnt == C_DRAIN_LAST) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_enc_req   = 1'b0;
      w_enc_bit   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_sym_idx  <= '0;
      r_enc_en   <= 1'b0;
      r_enc_din  <= 1'b0;
      r_dec_en   <= 1'b0;
      r_err_mask <= 2'b00;
      r_err_en   <= 1'b0;
      r_err_pat  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_hs || (r_state == ST_TAIL) || (r_state == ST_DRAIN)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_enc_en   <= w_enc_req;
      r_enc_din  <= w_enc_bit;
      r_dec_en   <= r_enc_en & ~w_abort;
      r_err_mask <= (w_err_hit & ~w_abort) ? r_err_pat : 2'b00;
      if (w_start_frame) begin
        r_sym_idx <= '0;
        r_err_en  <= err_en;
        r_err_pat <= err_pattern;
      end else if (r_enc_en) begin
        r_sym_idx <= r_sym_idx + SYM_W'(1);
      end
    end
  end

`ifdef VITERBI_CTRL_BER_COUNT_EN
  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int RD_W  = $clog2(FRAME_LEN + 1);

  logic               r_pay [2**IDX_W];
  logic [DEC_LAT-1:0] r_dec_dly;
  logic [RD_W-1:0]    r_rd_cnt;
  logic [15:0]        r_inj_cnt;
  logic [15:0]        r_dec_err_cnt;
  logic               w_chk;
  logic [16:0]        w_inj_sum;

  assign inj_bit_cnt = r_inj_cnt;
  assign dec_err_cnt = r_dec_err_cnt;
  assign w_chk       = r_dec_dly[DEC_LAT-1] & (r_rd_cnt < RD_W'(FRAME_LEN));
  assign w_inj_sum   = {1'b0, r_inj_cnt} + {16'd0, r_err_mask[1]} + {16'd0, r_err_mask[0]};

  // r_cnt equals the handshake count while in SEND, so it doubles as the write pointer
  always_ff @(posedge clk) begin
    if (w_hs) r_pay[r_cnt[IDX_W-1:0]] <= src_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_dly     <= '0;
      r_rd_cnt      <= '0;
      r_inj_cnt     <= '0;
      r_dec_err_cnt <= '0;
    end else if (w_start_frame) begin
      r_dec_dly     <= '0;
      r_rd_cnt      <= '0;
      r_inj_cnt     <= '0;
      r_dec_err_cnt <= '0;
    end else begin
      r_dec_dly <= w_abort ? '0 : ((r_dec_dly << 1) | DEC_LAT'(r_dec_en));
      r_inj_cnt <= w_inj_sum[16] ? 16'hFFFF : w_inj_sum[15:0];
      if (w_chk) begin
        r_rd_cnt <= r_rd_cnt + RD_W'(1);
        if ((dec_bit != r_pay[r_rd_cnt[IDX_W-1:0]]) && (r_dec_err_cnt != 16'hFFFF)) begin
          r_dec_err_cnt <= r_dec_err_cnt + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed bench: a small instance (8/2/4, period 4 symbols) for timing and control, a default instance for the error mask.
module tb_viterbi_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       s_start, s_abort, s_err_en, s_valid, s_bit;
  logic [1:0] s_err_pat;
  logic       s_ready, s_enc_en, s_enc_din, s_dec_en, s_busy, s_done;
  logic [1:0] s_err_mask;
  logic       d_start, d_abort, d_err_en, d_valid, d_bit;
  logic [1:0] d_err_pat;
  logic       d_ready, d_enc_en, d_enc_din, d_dec_en, d_busy, d_done;
  logic [1:0] d_err_mask;
  logic [7:0] s_vec, d_vec;

  int total = 0;
  int bad   = 0;

  viterbi_frame_ctrl #(.FRAME_LEN(8), .TAIL_LEN(2), .DEC_LAT(4), .ERR_PERIOD_LOG2(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .err_en(s_err_en),
    .err_pattern(s_err_pat), .src_valid(s_valid), .src_bit(s_bit), .src_ready(s_ready),
    .enc_en(s_enc_en), .enc_din(s_enc_din), .dec_en(s_dec_en), .err_mask(s_err_mask),
    .busy(s_busy), .frame_done(s_done)
  );

  viterbi_frame_ctrl u_dflt (
    .clk(clk), .rst(rst), .start(d_start), .abort(d_abort), .err_en(d_err_en),
    .err_pattern(d_err_pat), .src_valid(d_valid), .src_bit(d_bit), .src_ready(d_ready),
    .enc_en(d_enc_en), .enc_din(d_enc_din), .dec_en(d_dec_en), .err_mask(d_err_mask),
    .busy(d_busy), .frame_done(d_done)
  );

  assign s_vec = {s_ready, s_enc_en, s_enc_din, s_dec_en, s_err_mask, s_busy, s_done};
  assign d_vec = {d_ready, d_enc_en, d_enc_din, d_dec_en, d_err_mask, d_busy, d_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {src_ready,enc_en,enc_din,dec_en,err_mask,busy,frame_done} of the small instance
  // at cycle k of a frame started at cycle 0; handshake j lands on cycle 1+step*j.
  function automatic logic [7:0] exp_frame(int k, int step, logic [7:0] pat, logic [1:0] msk);
    int h;
    logic rdy, ee, ed, de, bz, fd;
    logic [1:0] em;
    h   = 1 + 7 * step;
    rdy = (k >= 1 && k <= h);
    ee = 1'b0; ed = 1'b0; de = 1'b0; em = 2'b00;
    for (int j = 0; j < 8; j++) begin
      if (k == 2 + step * j) begin ee = 1'b1; ed = pat[j]; end
      if (k == 3 + step * j) begin
        de = 1'b1;
        if (j == 2 || j == 3 || j == 6 || j == 7) em = msk;
      end
    end
    if (k >= h + 2 && k <= h + 7) ee = 1'b1;
    if (k >= h + 3 && k <= h + 8) de = 1'b1;
    bz = (k >= 1 && k <= h + 9);
    fd = (k == h + 9);
    return {rdy, ee, ed, de, em, bz, fd};
  endfunction

  task automatic idle_inputs();
    s_start = 0; s_abort = 0; s_err_en = 0; s_err_pat = 2'b00; s_valid = 0; s_bit = 0;
    d_start = 0; d_abort = 0; d_err_en = 0; d_err_pat = 2'b00; d_valid = 0; d_bit = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    total++;
    if (s_vec !== 8'h00) begin bad++; $display("FAIL reset_small got=%b exp=%b", s_vec, 8'h00); end
    total++;
    if (d_vec !== 8'h00) begin bad++; $display("FAIL reset_dflt got=%b exp=%b", d_vec, 8'h00); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      total++;
      if (s_vec !== 8'h00) begin bad++; $display("FAIL abort_in_idle cyc=%0d got=%b exp=%b", k, s_vec, 8'h00); end
      s_abort = (k < 3);
    end
  endtask

  task automatic test_basic(input logic [7:0] pat);
    logic [7:0] e;
    int n_enc, n_dec;
    n_enc = 0; n_dec = 0;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      e = exp_frame(k, 1, pat, 2'b00);
      total++;
      if (s_vec !== e) begin bad++; $display("FAIL basic cyc=%0d got=%b exp=%b", k, s_vec, e); end
      n_enc += int'(s_enc_en);
      n_dec += int'(s_dec_en);
      s_start = (k == 0);
      s_valid = 1'b1;
      s_bit   = (k >= 1 && k <= 8) ? pat[k-1] : 1'b1;
    end
    idle_inputs();
    total++;
    if (n_enc != 14) begin bad++; $display("FAIL basic_enc_pulses got=%0d exp=14", n_enc); end
    total++;
    if (n_dec != 14) begin bad++; $display("FAIL basic_dec_pulses got=%0d exp=14", n_dec); end
  endtask

  task automatic test_err_small();
    logic [7:0] pat, e;
    pat = 8'b0101_1100;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      e = exp_frame(k, 1, pat, 2'b10);
      total++;
      if (s_vec !== e) begin bad++; $display("FAIL err_small cyc=%0d got=%b exp=%b", k, s_vec, e); end
      s_start   = (k == 0);
      s_abort   = (k == 0);
      s_err_en  = (k == 0);
      s_err_pat = (k == 0) ? 2'b10 : 2'b01;
      s_valid   = 1'b1;
      s_bit     = (k >= 1 && k <= 8) ? pat[k-1] : 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    logic [7:0] pat, e;
    int n_pay;
    pat = 8'b0110_1101;
    n_pay = 0;
    for (int k = 0; k <= 27; k++) begin
      @(posedge clk); #1;
      e = exp_frame(k, 2, pat, 2'b00);
      total++;
      if (s_vec !== e) begin bad++; $display("FAIL stall cyc=%0d got=%b exp=%b", k, s_vec, e); end
      if (s_enc_en && k <= 16) n_pay++;
      s_start = (k == 0);
      s_valid = (k % 2 == 1);
      s_bit   = (k >= 1 && k <= 15 && (k % 2 == 1)) ? pat[(k-1)/2] : 1'b1;
    end
    idle_inputs();
    total++;
    if (n_pay != 8) begin bad++; $display("FAIL stall_payload_pulses got=%0d exp=8", n_pay); end
  endtask

  task automatic test_abort_tail();
    logic [7:0] pat, e;
    pat = 8'hA5;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      e = (k <= 9) ? exp_frame(k, 1, pat, 2'b11) : 8'h00;
      total++;
      if (s_vec !== e) begin bad++; $display("FAIL abort_tail cyc=%0d got=%b exp=%b", k, s_vec, e); end
      s_start   = (k == 0);
      s_err_en  = 1'b1;
      s_err_pat = 2'b11;
      s_abort   = (k == 9);
      s_valid   = 1'b1;
      s_bit     = (k >= 1 && k <= 8) ? pat[k-1] : 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_start_busy_rst();
    logic [7:0] pat, e;
    pat = 8'b1100_1010;
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      e = exp_frame(k, 1, pat, 2'b00);
      total++;
      if (s_vec !== e) begin bad++; $display("FAIL start_busy cyc=%0d got=%b exp=%b", k, s_vec, e); end
      s_start   = (k == 0 || k == 4);
      s_err_en  = (k == 4);
      s_err_pat = (k == 4) ? 2'b11 : 2'b00;
      s_valid   = 1'b1;
      s_bit     = (k >= 1 && k <= 8) ? pat[k-1] : 1'b0;
    end
    idle_inputs();
    #3 rst = 1'b1;
    #1;
    total++;
    if (s_vec !== 8'h00) begin bad++; $display("FAIL rst_mid_drain got=%b exp=%b", s_vec, 8'h00); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      total++;
      if (s_vec !== 8'h00) begin bad++; $display("FAIL after_rst cyc=%0d got=%b exp=%b", k, s_vec, 8'h00); end
    end
  endtask

  task automatic test_defaults_err();
    int sym, n_mask, done_cyc;
    logic [1:0] em;
    sym = 0; n_mask = 0; done_cyc = -1;
    for (int k = 0; k <= 280; k++) begin
      @(posedge clk); #1;
      if (d_dec_en) begin
        em = (sym < 256 && (sym % 16 == 14 || sym % 16 == 15)) ? 2'b01 : 2'b00;
        total++;
        if (d_err_mask !== em) begin bad++; $display("FAIL dflt_mask sym=%0d got=%b exp=%b", sym, d_err_mask, em); end
        sym++;
      end else if (d_err_mask !== 2'b00) begin
        total++;
        bad++;
        $display("FAIL dflt_mask_no_dec cyc=%0d got=%b exp=00", k, d_err_mask);
      end
      if (d_err_mask != 2'b00) n_mask++;
      if (d_done && done_cyc < 0) done_cyc = k;
      if (k == 278) begin
        total++;
        if (d_busy !== 1'b0) begin bad++; $display("FAIL dflt_busy_after_done got=%b exp=0", d_busy); end
      end
      d_start   = (k == 0);
      d_err_en  = 1'b1;
      d_err_pat = 2'b01;
      d_valid   = 1'b1;
      d_bit     = 1'($urandom_range(1, 0));
    end
    idle_inputs();
    total++;
    if (n_mask != 32) begin bad++; $display("FAIL dflt_mask_count got=%0d exp=32", n_mask); end
    total++;
    if (sym != 274) begin bad++; $display("FAIL dflt_dec_pulses got=%0d exp=274", sym); end
    total++;
    if (done_cyc != 277) begin bad++; $display("FAIL dflt_done_cycle got=%0d exp=277", done_cyc); end
  endtask

  initial begin
    test_reset();
    test_basic(8'b1011_0010);
    test_err_small();
    test_stall();
    test_abort_tail();
    test_basic(8'b0011_1001);
    test_start_busy_rst();
    test_defaults_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the convolutional-encoder -> channel -> Viterbi-decoder link.
- Pulls payload bits from a serial source over a valid/ready handshake.
- Drives encoder enable/data, appends tail (flush) zeros, then keeps clocking the decoder through its traceback latency.
- Generates the channel error-injection mask and the decoder enable.
- Signals frame completion.

Parameters:
- FRAME_LEN, 256, payload bits per frame (>=2).
- TAIL_LEN, 2, zero flush bits appended (constraint length K-1).
- DEC_LAT, 16, extra zero-input cycles issued so the decoder drains traceback (>=1).
- ERR_PERIOD_LOG2, 4, error burst period is 2**ERR_PERIOD_LOG2 symbols (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  terminate the current frame
- err_en  in  1  enable error injection; latched at start
- err_pattern  in  2  XOR pattern applied to coded symbol; latched at start
- src_valid  in  1  source bit valid
- src_bit  in  1  source payload bit
- src_ready  out  1  controller accepts src_bit
- enc_en  out  1  encoder enable (to enable_i)
- enc_din  out  1  encoder data in
- dec_en  out  1  decoder enable, aligned with encoder valid output
- err_mask  out  2  XOR mask for the coded symbol, aligned with dec_en
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Counters and latched err_en/err_pattern cleared.
- States: IDLE, SEND, TAIL, DRAIN, DONE.
- IDLE: start=1 at cycle t -> SEND at t+1; err_en and err_pattern latched at t.
- SEND: src_ready = (state==SEND), combinational from the state register.
  - Handshake (src_valid & src_ready) at cycle t -> enc_en=1, enc_din=src_bit at t+1 (registered).
  - No handshake -> enc_en=0 next cycle. Source stalls insert bubbles; nothing is lost or duplicated.
  - The FRAME_LEN-th handshake moves the state to TAIL.
- TAIL: TAIL_LEN consecutive cycles with enc_en=1, enc_din=0, then DRAIN.
- DRAIN: DEC_LAT consecutive cycles with enc_en=1, enc_din=0, then DONE.
- DONE: frame_done=1 for exactly one cycle, then IDLE. busy falls in the same cycle frame_done falls.
- dec_en is enc_en delayed exactly 1 cycle, matching the encoder's 1-cycle valid latency.
- Symbol index sym_idx:
  - Counts dec_en cycles within the frame, starting at 0.
  - Width $clog2(FRAME_LEN+TAIL_LEN+DEC_LAT+1).
  - Clears on entry to SEND.
- err_mask:
  - Equals latched err_pattern when dec_en=1, latched err_en=1, sym_idx < FRAME_LEN+TAIL_LEN, and sym_idx[ERR_PERIOD_LOG2-1:1] is all ones.
  - Otherwise 0.
  - Never nonzero while dec_en=0, and never nonzero during drain symbols.
- abort=1 in any non-IDLE state: next cycle state is IDLE, and enc_en, dec_en, err_mask are all 0. No frame_done. The pipelined dec_en is squashed too.
  - abort has priority over all other transitions.
  - abort in IDLE has no effect.
- start while busy is ignored; it is neither queued nor re-latched.
- start and abort both high in IDLE: start wins.
- Total enc_en pulses per uninterrupted frame: FRAME_LEN+TAIL_LEN+DEC_LAT. dec_en pulse count is identical.

Optional Feature:
VITERBI_CTRL_BER_COUNT_EN
- Defined:
  - Adds output inj_bit_cnt (16 bits): counts flipped bits per frame, i.e. the popcount of err_mask, summed.
  - Adds input dec_bit (decoder output) and output dec_err_cnt (16 bits).
  - Payload bits are stored in a FRAME_LEN-deep shift FIFO. Decoded bits arriving on the first FRAME_LEN cycles with dec_en delayed by DEC_LAT are compared against the stored bits; mismatches are counted.
  - Both counters clear at start, hold after frame_done, and saturate at 16'hFFFF.
- Undefined: those ports and the logic do not exist.

Test Plan:
- FRAME_LEN=8, TAIL_LEN=2, DEC_LAT=4, err_en=0, src_valid held 1, start at cycle 0:
  - src_ready high cycles 1-8.
  - enc_en high cycles 2-15; enc_din=0 on cycles 10-15.
  - dec_en high cycles 3-16; err_mask always 0.
  - frame_done pulse at cycle 17; busy low from cycle 18.
- Defaults with err_en=1, err_pattern=2'b01:
  - err_mask=01 exactly at sym_idx 14,15,30,31,...,254,255 (32 symbols). Tail symbols 256 and 257 stay 0.
- Source stall: src_valid toggles 1,0,1,0 over a FRAME_LEN=8 frame:
  - enc_en shows matching bubbles; exactly 8 payload pulses with the bit sequence preserved.
  - frame_done delayed by the stall count.
- abort in the TAIL state:
  - Next cycle IDLE; enc_en/dec_en/err_mask 0; no frame_done.
  - A fresh start then runs a full, correct frame.
- start pulsed mid-SEND, and rst asserted mid-DRAIN:
  - start is ignored.
  - rst forces all outputs to 0 immediately, asynchronously, with no frame_done.
- With VITERBI_CTRL_BER_COUNT_EN, defaults, err_pattern=2'b11:
  - inj_bit_cnt=64 at frame_done.
  - dec_err_cnt=0 with a correct decoder; forcing dec_bit inverted gives 256.
